// File: rtl/dma_page_writer_pkg.sv
// dma_page_writer_pkg: shared constants and types for the
// SDRAM DMA page writer and its helpers.
package dma_page_writer_pkg;

    localparam int PAGE_WORDS = 256;
    localparam int PAGE_AW    = 8;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT_LOW
    } req_state_t;

endpackage

// File: rtl/dma_page_writer_if.sv
// dma_page_writer_if: job control, word stream, line-buffer write
// port and SDRAM arbiter handshake of the DMA page writer.
interface dma_page_writer_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [ADDR_W-1:0] base_page;
    logic [ADDR_W-1:0] page_count;
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_ready;
    logic [15:0]       buf_wr_data;
    logic [7:0]        buf_wr_addr;
    logic              buf_wr_en_a;
    logic              buf_wr_en_b;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_a_b;
    logic              dma_ack;
    logic              is_dma;
    logic              done;

    modport master (
        input  start, base_page, page_count,
        input  in_valid, in_data, dma_ack,
        output in_ready, buf_wr_data, buf_wr_addr,
        output buf_wr_en_a, buf_wr_en_b,
        output dma_req, dma_addr, dma_a_b,
        output is_dma, done
    );

    modport slave (
        output start, base_page, page_count,
        output in_valid, in_data, dma_ack,
        input  in_ready, buf_wr_data, buf_wr_addr,
        input  buf_wr_en_a, buf_wr_en_b,
        input  dma_req, dma_addr, dma_a_b,
        input  is_dma, done
    );
endinterface

// File: rtl/dma_page_writer_sync_ff.sv
// sync_ff: multi-flop synchroniser for a single-bit signal
// arriving from another clock domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    // shift the async input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/dma_page_writer.sv
// dma_page_writer: packs a word stream into ping-pong line-buffer pages
// and hands each full page to the SDRAM arbiter via a 4-phase req/ack.
module dma_page_writer
    import dma_page_writer_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    dma_page_writer_if.master bus
);
    logic               is_dma_q, done_q;
    logic               dma_req_q, dma_a_b_q;
    logic [ADDR_W-1:0]  dma_addr_q;
    logic [ADDR_W-1:0]  base_q, count_q;
    logic [ADDR_W-1:0]  filled_q, issued_q, issued_inc;
    logic               fill_sel, req_sel;
    logic               full_a, full_b;
    logic [PAGE_AW-1:0] fill_cnt;
    logic               ack_s;
    logic               fill_full, req_full;
    logic               in_ready_c, accept, wrap;
    logic               job_start, launch, release_pg;
    req_state_t         state, state_nxt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (bus.dma_ack),
        .q     (ack_s)
    );

    assign fill_full  = (fill_sel == SEL_A) ? full_a : full_b;
    assign req_full   = (req_sel == SEL_A) ? full_a : full_b;
    assign in_ready_c = is_dma_q && !fill_full && (filled_q < count_q);
    assign accept     = bus.in_valid && in_ready_c;
    assign wrap       = accept && (int'(fill_cnt) == PAGE_WORDS - 1);
    assign job_start  = !is_dma_q && bus.start;
    assign issued_inc = issued_q + ADDR_W'(1);

    // request FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= R_IDLE;
        else            state <= state_nxt;
    end

    // request FSM next state; stale ack keeps us idle until it drops
    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        release_pg = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (is_dma_q && req_full && !ack_s) begin
                    state_nxt = R_REQ;
                    launch    = 1'b1;
                end
            end
            R_REQ: begin
                if (ack_s) state_nxt = R_WAIT_LOW;
            end
            R_WAIT_LOW: begin
                if (!ack_s) begin
                    state_nxt  = R_IDLE;
                    release_pg = 1'b1;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    // request outputs: address and buffer held for the whole req phase
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dma_req_q  <= 1'b0;
            dma_addr_q <= '0;
            dma_a_b_q  <= 1'b0;
        end else if (launch) begin
            dma_req_q  <= 1'b1;
            dma_addr_q <= base_q + issued_q;
            dma_a_b_q  <= (req_sel == SEL_A);
        end else if (state == R_REQ && ack_s) begin
            dma_req_q  <= 1'b0;
        end
    end

    // job control, fill counters and buffer ping-pong selects
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            is_dma_q <= 1'b0;
            done_q   <= 1'b0;
            base_q   <= '0;
            count_q  <= '0;
            filled_q <= '0;
            issued_q <= '0;
            fill_cnt <= '0;
            fill_sel <= SEL_A;
            req_sel  <= SEL_A;
        end else if (job_start) begin
            base_q   <= bus.base_page;
            count_q  <= bus.page_count;
            filled_q <= '0;
            issued_q <= '0;
            fill_cnt <= '0;
            fill_sel <= SEL_A;
            req_sel  <= SEL_A;
            is_dma_q <= (bus.page_count != '0);
            done_q   <= (bus.page_count == '0);
        end else begin
            done_q <= 1'b0;
            if (accept) fill_cnt <= fill_cnt + PAGE_AW'(1);
            if (wrap) begin
                fill_sel <= ~fill_sel;
                filled_q <= filled_q + ADDR_W'(1);
            end
            if (release_pg) begin
                req_sel  <= ~req_sel;
                issued_q <= issued_inc;
                if (issued_inc == count_q) begin
                    done_q   <= 1'b1;
                    is_dma_q <= 1'b0;
                end
            end
        end
    end

    // full flags: set by the filler, cleared by the requester
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            full_a <= 1'b0;
            full_b <= 1'b0;
        end else if (job_start) begin
            full_a <= 1'b0;
            full_b <= 1'b0;
        end else begin
            if (release_pg && req_sel == SEL_A)    full_a <= 1'b0;
            else if (wrap && fill_sel == SEL_A)    full_a <= 1'b1;
            if (release_pg && req_sel == SEL_B)    full_b <= 1'b0;
            else if (wrap && fill_sel == SEL_B)    full_b <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.buf_wr_data = accept ? bus.in_data : 16'h0000;
    assign bus.buf_wr_addr = fill_cnt;
    assign bus.buf_wr_en_a = accept && (fill_sel == SEL_A);
    assign bus.buf_wr_en_b = accept && (fill_sel == SEL_B);
    assign bus.dma_req     = dma_req_q;
    assign bus.dma_addr    = dma_addr_q;
    assign bus.dma_a_b     = dma_a_b_q;
    assign bus.is_dma      = is_dma_q;
    assign bus.done        = done_q;
endmodule
